reg_wb_queue: RTL and testbench
===============================

// Module: reg_wb_queue
// PURPOSE
//  Write-side initiator for the 32x32 register file. Buffers register-write requests from
//  multi-cycle producers (load unit, mul/div) in a small FIFO and drains one per cycle onto
//  the register file write port (RegWrite/regW/Wdat).
//  Provides two forwarding lookups, so decode sees pending values not yet committed.
// PARAMETERS
//  DEPTH   4   queue entries (power of 2, >=2)
//  DATA_W  32  register data width
//  ADDR_W  5   register index width (32 regs)
// PORTS
//  clk        in   1       clock, all state on posedge
//  rst        in   1       synchronous, active-high reset
//  in_valid   in   1       producer has a write request
//  in_ready   out  1       queue accepts request this cycle
//  in_reg     in   ADDR_W  destination register
//  in_data    in   DATA_W  value to write
//  wb_hold    in   1       1 = do not drain this cycle (external port owner)
//  RegWrite   out  1       register file write enable
//  regW       out  ADDR_W  register file write index
//  Wdat       out  DATA_W  register file write data
//  fa_reg     in   ADDR_W  forwarding lookup A index
//  fa_hit     out  1       A has a pending write
//  fa_dat     out  DATA_W  newest pending value for A
//  fb_reg     in   ADDR_W  forwarding lookup B index
//  fb_hit     out  1       B has a pending write
//  fb_dat     out  DATA_W  newest pending value for B
//  count      out  $clog2(DEPTH+1)  occupancy
// BEHAVIOUR
//  - Clock clk; reset rst is synchronous, active-high. Sampled rst=1 clears rd/wr pointers
//    and count; pending entries are discarded, never written.
//  - While rst=1 (combinational): in_ready=0, RegWrite=0.
//  - Reset values: count=0, RegWrite=0, regW=0, Wdat=0, fa/fb_hit=0, fa/fb_dat=0.
//  - drain = (count!=0) & ~wb_hold & ~rst. RegWrite=drain. regW/Wdat = head entry when
//    count!=0, else 0. No hold-off from the register file; a drain always commits on that edge.
//  - in_ready = ~rst & ((count<DEPTH) | drain). enq = in_valid & in_ready.
//  - enq & in_reg==0: accepted and dropped ($0 is always 0). No entry, count unchanged.
//  - Latency: request enqueued at edge N -> earliest RegWrite=1 in cycle N+1 (no bypass
//    around the FIFO). Order is strictly FIFO, including repeated writes to the same reg.
//  - Simultaneous enq+drain: both occur, count unchanged; legal when full (slot frees).
//  - Pointers wrap modulo DEPTH; count saturates at neither end (guarded by ready/drain).
//  - Forwarding (combinational over stored entries only, head included): hit if any valid
//    entry addr == lookup reg; dat = youngest matching entry. A request being enqueued this
//    cycle is not visible. Lookup reg 0 never hits. No hit -> dat=0.
//  - The head being drained this cycle still hits. The register file updates only at that
//    edge, so the forwarded value is correct.
//  - wb_hold=1 with count=DEPTH: in_ready=0 until hold releases.
// STRUCTURE
//  - Shared package reg_wb_pkg: REG_ADDR_W=5, REG_DATA_W=32, ZERO_REG=5'd0,
//    typedef struct {addr, data} wb_entry_t.
//  - Sub-module reg_wb_fwd: youngest-match priority search over DEPTH entries, given
//    entries, valid mask, head pointer and lookup index. Instantiated twice (A, B).
//  - Top holds entry array, pointers, count, handshake logic.
// TESTING
//  1. rst 1 cycle, in_valid=0 -> count=0, RegWrite=0, regW=0, Wdat=0, in_ready=1.
//  2. enq (r5,0xDEADBEEF) cycle 0 -> cycle 1 RegWrite=1, regW=5, Wdat=0xDEADBEEF, fa_reg=5
//     hit with same dat; cycle 2 count=0, fa_hit=0.
//  3. wb_hold=1, enq r3=1, r7=2, r3=3, r9=4 -> count=4, in_ready=0, fa_reg=3 gives dat=3.
//     Release -> drains r3=1, r7=2, r3=3, r9=4 on 4 consecutive cycles.
//  4. Full + hold=0 + in_valid (r1,0x11) -> in_ready=1, count stays 4, r1 commits 4 cycles later.
//  5. enq (r0,0x55) -> in_ready=1, count stays 0, RegWrite never asserts, fa_reg=0 no hit.
//  6. 3 entries queued, rst=1 one cycle -> RegWrite=0 and in_ready=0 during rst. Next cycle
//     count=0, no queued value ever written.

Source files
------------

// File: rtl/reg_wb_pkg.sv
// Shared types and constants for the register-file write-back path.
package reg_wb_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned REG_DATA_W = 32;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/reg_wb_fwd.sv
// Youngest-match forwarding search over the write-back queue entries.
module reg_wb_fwd
  import reg_wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  wb_entry_t [DEPTH-1:0]      i_entries,
  input  logic      [DEPTH-1:0]      i_valid,
  input  logic      [PTR_W-1:0]      i_head,
  input  logic      [REG_ADDR_W-1:0] i_reg,
  output logic                       o_hit,
  output logic      [REG_DATA_W-1:0] o_dat
);

  logic [PTR_W-1:0] w_idx;

  // Walk from oldest (head) to youngest so the last match wins.
  always_comb begin
    o_hit = 1'b0;
    o_dat = '0;
    w_idx = '0;
    for (int k = 0; k < int'(DEPTH); k++) begin
      w_idx = i_head + PTR_W'(k);
      if (i_valid[w_idx] && (i_entries[w_idx].addr == i_reg) && (i_reg != ZERO_REG)) begin
        o_hit = 1'b1;
        o_dat = i_entries[w_idx].data;
      end
    end
  end

endmodule

// File: rtl/reg_wb_queue.sv
// Write-back FIFO in front of the register file write port, with two forwarding lookups.
module reg_wb_queue
  import reg_wb_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = REG_DATA_W,
  parameter int unsigned ADDR_W = REG_ADDR_W,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_reg,
  input  logic [DATA_W-1:0] in_data,
  input  logic              wb_hold,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] regW,
  output logic [DATA_W-1:0] Wdat,
  input  logic [ADDR_W-1:0] fa_reg,
  output logic              fa_hit,
  output logic [DATA_W-1:0] fa_dat,
  input  logic [ADDR_W-1:0] fb_reg,
  output logic              fb_hit,
  output logic [DATA_W-1:0] fb_dat,
  output logic [CNT_W-1:0]  count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  wb_entry_t [DEPTH-1:0] r_mem;
  logic [PTR_W-1:0]      r_rd;
  logic [PTR_W-1:0]      r_wr;
  logic [CNT_W-1:0]      r_count;

  logic                  w_nonempty;
  logic                  w_drain;
  logic                  w_enq;
  logic                  w_push;
  logic [DEPTH-1:0]      w_valid;
  logic [PTR_W-1:0]      w_age;
  wb_entry_t             w_head;
  logic [REG_DATA_W-1:0] w_fa_dat;
  logic [REG_DATA_W-1:0] w_fb_dat;

  assign w_nonempty = (r_count != '0);
  assign w_drain    = w_nonempty & ~wb_hold & ~rst;
  assign in_ready   = ~rst & ((r_count < CNT_W'(DEPTH)) | w_drain);
  assign w_enq      = in_valid & in_ready;
  // Writes to $0 are accepted but never stored.
  assign w_push     = w_enq & (in_reg != ADDR_W'(0));

  assign w_head   = r_mem[r_rd];
  assign RegWrite = w_drain;
  assign regW     = w_nonempty ? ADDR_W'(w_head.addr) : '0;
  assign Wdat     = w_nonempty ? DATA_W'(w_head.data) : '0;
  assign count    = r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + PTR_W'(1);
      if (w_drain) r_rd <= r_rd + PTR_W'(1);
      case ({w_push, w_drain})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage needs no reset; validity comes from pointers and count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr].addr <= REG_ADDR_W'(in_reg);
      r_mem[r_wr].data <= REG_DATA_W'(in_data);
    end
  end

  always_comb begin
    w_valid = '0;
    w_age   = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      w_age      = PTR_W'(i) - r_rd;
      w_valid[i] = (CNT_W'(w_age) < r_count);
    end
  end

  reg_wb_fwd #(.DEPTH(DEPTH)) u_fwd_a (
    .i_entries (r_mem),
    .i_valid   (w_valid),
    .i_head    (r_rd),
    .i_reg     (REG_ADDR_W'(fa_reg)),
    .o_hit     (fa_hit),
    .o_dat     (w_fa_dat)
  );

  reg_wb_fwd #(.DEPTH(DEPTH)) u_fwd_b (
    .i_entries (r_mem),
    .i_valid   (w_valid),
    .i_head    (r_rd),
    .i_reg     (REG_ADDR_W'(fb_reg)),
    .o_hit     (fb_hit),
    .o_dat     (w_fb_dat)
  );

  assign fa_dat = DATA_W'(w_fa_dat);
  assign fb_dat = DATA_W'(w_fb_dat);

endmodule

// File: tb/tb_reg_wb_queue.sv
// Directed bench for reg_wb_queue: handshake, ordering, forwarding, $0 drop and reset flush.
module tb_reg_wb_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_reg;
  logic [31:0] in_data;
  logic        wb_hold;
  logic        RegWrite;
  logic [4:0]  regW;
  logic [31:0] Wdat;
  logic [4:0]  fa_reg;
  logic        fa_hit;
  logic [31:0] fa_dat;
  logic [4:0]  fb_reg;
  logic        fb_hit;
  logic [31:0] fb_dat;
  logic [2:0]  count;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  reg_wb_queue dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_reg   (in_reg),
    .in_data  (in_data),
    .wb_hold  (wb_hold),
    .RegWrite (RegWrite),
    .regW     (regW),
    .Wdat     (Wdat),
    .fa_reg   (fa_reg),
    .fa_hit   (fa_hit),
    .fa_dat   (fa_dat),
    .fb_reg   (fb_reg),
    .fb_hit   (fb_hit),
    .fb_dat   (fb_dat),
    .count    (count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] r, input logic [31:0] d);
    in_valid = v;
    in_reg   = r;
    in_data  = d;
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_reg = '0; in_data = '0;
    wb_hold = 1'b0; fa_reg = '0; fb_reg = '0;
    #2;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_regwrite", 32'(RegWrite), 32'd0);
    step();
    rst = 1'b0;
    #1;

    // 1: reset state
    chk("t1_count", 32'(count), 32'd0);
    chk("t1_regwrite", 32'(RegWrite), 32'd0);
    chk("t1_regW", 32'(regW), 32'd0);
    chk("t1_Wdat", Wdat, 32'd0);
    chk("t1_in_ready", 32'(in_ready), 32'd1);
    chk("t1_fa_hit", 32'(fa_hit), 32'd0);
    chk("t1_fa_dat", fa_dat, 32'd0);

    // 2: single write, one-cycle latency, forwarding of head being drained
    fa_reg = 5'd5;
    drive(1'b1, 5'd5, 32'hDEADBEEF);
    chk("t2_ready", 32'(in_ready), 32'd1);
    chk("t2_no_bypass_hit", 32'(fa_hit), 32'd0);
    chk("t2_no_bypass_we", 32'(RegWrite), 32'd0);
    step();
    drive(1'b0, 5'd0, 32'd0);
    chk("t2_count1", 32'(count), 32'd1);
    chk("t2_regwrite", 32'(RegWrite), 32'd1);
    chk("t2_regW", 32'(regW), 32'd5);
    chk("t2_Wdat", Wdat, 32'hDEADBEEF);
    chk("t2_fa_hit", 32'(fa_hit), 32'd1);
    chk("t2_fa_dat", fa_dat, 32'hDEADBEEF);
    step();
    chk("t2_count0", 32'(count), 32'd0);
    chk("t2_fa_hit_gone", 32'(fa_hit), 32'd0);
    chk("t2_regwrite_off", 32'(RegWrite), 32'd0);

    // 3: held fill, youngest-match forwarding, ordered drain
    wb_hold = 1'b1;
    drive(1'b1, 5'd3, 32'd1); step();
    drive(1'b1, 5'd7, 32'd2); step();
    drive(1'b1, 5'd3, 32'd3); step();
    drive(1'b1, 5'd9, 32'd4); step();
    drive(1'b1, 5'd12, 32'd99);
    fa_reg = 5'd3; fb_reg = 5'd7;
    #1;
    chk("t3_count", 32'(count), 32'd4);
    chk("t3_ready_full", 32'(in_ready), 32'd0);
    chk("t3_we_held", 32'(RegWrite), 32'd0);
    chk("t3_fa_hit", 32'(fa_hit), 32'd1);
    chk("t3_fa_young", fa_dat, 32'd3);
    chk("t3_fb_dat", fb_dat, 32'd2);
    step();
    chk("t3_count_still", 32'(count), 32'd4);
    drive(1'b0, 5'd0, 32'd0);
    wb_hold = 1'b0;
    #1;
    chk("t3_d0_we", 32'(RegWrite), 32'd1);
    chk("t3_d0_reg", 32'(regW), 32'd3);
    chk("t3_d0_dat", Wdat, 32'd1);
    step();
    chk("t3_d1_reg", 32'(regW), 32'd7);
    chk("t3_d1_dat", Wdat, 32'd2);
    chk("t3_d1_fa", fa_dat, 32'd3);
    step();
    chk("t3_d2_reg", 32'(regW), 32'd3);
    chk("t3_d2_dat", Wdat, 32'd3);
    step();
    chk("t3_d3_we", 32'(RegWrite), 32'd1);
    chk("t3_d3_reg", 32'(regW), 32'd9);
    chk("t3_d3_dat", Wdat, 32'd4);
    step();
    chk("t3_empty", 32'(count), 32'd0);
    chk("t3_fa_gone", 32'(fa_hit), 32'd0);

    // 4: enqueue into a full queue while draining
    wb_hold = 1'b1;
    drive(1'b1, 5'd2, 32'hA0); step();
    drive(1'b1, 5'd4, 32'hA1); step();
    drive(1'b1, 5'd6, 32'hA2); step();
    drive(1'b1, 5'd8, 32'hA3); step();
    wb_hold = 1'b0;
    drive(1'b1, 5'd1, 32'h11);
    chk("t4_ready_full_drain", 32'(in_ready), 32'd1);
    chk("t4_drain_reg", 32'(regW), 32'd2);
    step();
    drive(1'b0, 5'd0, 32'd0);
    chk("t4_count", 32'(count), 32'd4);
    chk("t4_c1_reg", 32'(regW), 32'd4);
    step();
    chk("t4_c2_reg", 32'(regW), 32'd6);
    step();
    chk("t4_c3_reg", 32'(regW), 32'd8);
    step();
    chk("t4_c4_we", 32'(RegWrite), 32'd1);
    chk("t4_c4_reg", 32'(regW), 32'd1);
    chk("t4_c4_dat", Wdat, 32'h11);
    step();
    chk("t4_empty", 32'(count), 32'd0);

    // 5: writes to $0 are swallowed
    fa_reg = 5'd0;
    drive(1'b1, 5'd0, 32'h55);
    chk("t5_ready", 32'(in_ready), 32'd1);
    chk("t5_fa_zero", 32'(fa_hit), 32'd0);
    step();
    drive(1'b0, 5'd0, 32'd0);
    chk("t5_count", 32'(count), 32'd0);
    chk("t5_we", 32'(RegWrite), 32'd0);
    chk("t5_fa_zero2", 32'(fa_hit), 32'd0);
    step();
    chk("t5_we2", 32'(RegWrite), 32'd0);

    // 6: reset discards queued entries
    wb_hold = 1'b1;
    drive(1'b1, 5'd10, 32'hB0); step();
    drive(1'b1, 5'd11, 32'hB1); step();
    drive(1'b1, 5'd12, 32'hB2); step();
    drive(1'b0, 5'd0, 32'd0);
    chk("t6_count3", 32'(count), 32'd3);
    wb_hold = 1'b0;
    rst = 1'b1;
    #1;
    chk("t6_rst_we", 32'(RegWrite), 32'd0);
    chk("t6_rst_ready", 32'(in_ready), 32'd0);
    step();
    rst = 1'b0;
    fa_reg = 5'd10;
    #1;
    chk("t6_count0", 32'(count), 32'd0);
    chk("t6_we", 32'(RegWrite), 32'd0);
    chk("t6_fa", 32'(fa_hit), 32'd0);
    chk("t6_ready", 32'(in_ready), 32'd1);
    step();
    chk("t6_we_later", 32'(RegWrite), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
